// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI constants and FSM state encodings for the burst RAM
package axi_pkg;
  localparam int ID_W  = 4;
  localparam int LEN_W = 8;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
endpackage

// File: rtl/bwe_ram_1r1w.sv
// rtl/bwe_ram_1r1w.sv - 32-bit RAM, asynchronous read port, synchronous byte-enable write port
module bwe_ram_1r1w #(
  parameter int    AW        = 12,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_strb
);
  logic [31:0] mem [0:(1<<AW)-1];

  // The read port sees the array before this cycle's write commits.
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end
endmodule

// File: rtl/axi_burst_ram.sv
// rtl/axi_burst_ram.sv - AXI3 INCR-burst slave memory, independent read and write engines
module axi_burst_ram
  import axi_pkg::*;
#(
  parameter int    MEM_WORDS_LOG2 = 12,
  parameter int    RD_LATENCY     = 2,
  parameter string INIT_FILE      = ""
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ID_W-1:0]  arid,
  input  logic [31:0]      araddr,
  input  logic [LEN_W-1:0] arlen,
  input  logic [2:0]       arsize,
  input  logic [1:0]       arburst,
  input  logic [1:0]       arlock,
  input  logic [3:0]       arcache,
  input  logic [2:0]       arprot,
  input  logic             arvalid,
  output logic             arready,
  output logic [ID_W-1:0]  rid,
  output logic [31:0]      rdata,
  output logic [1:0]       rresp,
  output logic             rlast,
  output logic             rvalid,
  input  logic             rready,
  input  logic [ID_W-1:0]  awid,
  input  logic [31:0]      awaddr,
  input  logic [LEN_W-1:0] awlen,
  input  logic [2:0]       awsize,
  input  logic [1:0]       awburst,
  input  logic [1:0]       awlock,
  input  logic [3:0]       awcache,
  input  logic [2:0]       awprot,
  input  logic             awvalid,
  output logic             awready,
  input  logic [ID_W-1:0]  wid,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             wlast,
  input  logic             wvalid,
  output logic             wready,
  output logic [ID_W-1:0]  bid,
  output logic [1:0]       bresp,
  output logic             bvalid,
  input  logic             bready
);
  localparam int AW = MEM_WORDS_LOG2;

  rd_state_e        rd_state;
  wr_state_e        wr_state;
  logic [AW-1:0]    rd_addr, wr_addr;
  logic [LEN_W-1:0] rd_len, rd_beat, wr_len, wr_beat;
  logic [3:0]       rd_lat;
  logic             rd_held;
  logic [31:0]      rdata_q, ram_rd;
  logic             ram_we;
  logic             unused_ok;

  assign rresp  = RESP_OKAY;
  assign ram_we = wvalid & wready & ~reset;
  // A beat shows live memory on its first cycle; if stalled, the captured copy is held.
  assign rdata  = rd_held ? rdata_q : (rvalid ? ram_rd : 32'd0);

  assign unused_ok = ^{arsize, arburst == BURST_INCR, awsize, awburst, wid, arlock, arcache,
                       arprot, awlock, awcache, awprot, araddr[31:AW+2], araddr[1:0],
                       awaddr[31:AW+2], awaddr[1:0]};

  bwe_ram_1r1w #(.AW(AW), .INIT_FILE(INIT_FILE)) u_ram (
    .clk     (clk),
    .rd_addr (rd_addr),
    .rd_data (ram_rd),
    .wr_en   (ram_we),
    .wr_addr (wr_addr),
    .wr_data (wdata),
    .wr_strb (wstrb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= R_IDLE;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rdata_q  <= '0;
      rd_held  <= 1'b0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_beat  <= '0;
      rd_lat   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            rid     <= arid;
            rd_addr <= araddr[AW+1:2];
            rd_len  <= arlen;
            rd_beat <= '0;
            rd_lat  <= 4'(RD_LATENCY - 1);
            if (RD_LATENCY == 1) begin
              rd_state <= R_DATA;
              rvalid   <= 1'b1;
              rlast    <= (arlen == '0);
            end else begin
              rd_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          rd_lat <= rd_lat - 4'd1;
          if (rd_lat == 4'd1) begin
            rd_state <= R_DATA;
            rvalid   <= 1'b1;
            rlast    <= (rd_len == '0);
          end
        end
        R_DATA: begin
          if (rready) begin
            rd_held <= 1'b0;
            if (rlast) begin
              rd_state <= R_IDLE;
              rvalid   <= 1'b0;
              rlast    <= 1'b0;
              arready  <= 1'b1;
            end else begin
              rd_addr <= rd_addr + 1'b1;
              rd_beat <= rd_beat + 8'd1;
              rlast   <= (rd_beat + 8'd1 == rd_len);
            end
          end else if (!rd_held) begin
            rdata_q <= ram_rd;
            rd_held <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= RESP_OKAY;
      wr_addr  <= '0;
      wr_len   <= '0;
      wr_beat  <= '0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awvalid && awready) begin
            awready  <= 1'b0;
            wready   <= 1'b1;
            bid      <= awid;
            wr_addr  <= awaddr[AW+1:2];
            wr_len   <= awlen;
            wr_beat  <= '0;
            wr_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wready) begin
            wr_addr <= wr_addr + 1'b1;
            wr_beat <= wr_beat + 8'd1;
            // Early or missing wlast still closes the burst, but is flagged.
            if (wlast || wr_beat == wr_len) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              bresp    <= (wlast && wr_beat == wr_len) ? RESP_OKAY : RESP_SLVERR;
              wr_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_ram.sv
// tb/tb_axi_burst_ram.sv - randomized bench for axi_burst_ram against an array reference model
module tb_axi_burst_ram;
  localparam int RD_LATENCY = 2;
  localparam int DEPTH      = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_burst_ram #(.MEM_WORDS_LOG2(12), .RD_LATENCY(RD_LATENCY), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  logic [31:0] ref_mem   [DEPTH];
  logic [31:0] wbuf_data [256];
  logic [3:0]  wbuf_strb [256];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_write(input logic [11:0] w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input int stop_beat);
    int n;
    int last_beat;
    logic [11:0] w;
    last_beat = (stop_beat >= 0 && stop_beat < len) ? stop_beat : len;
    @(negedge clk);
    awaddr = addr; awlen = 8'(len); awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("aw_timeout", 32'd0, 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    w = addr[13:2];
    for (int beat = 0; beat <= last_beat; beat++) begin
      wdata = wbuf_data[beat]; wstrb = wbuf_strb[beat];
      wlast = (beat == last_beat); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) check("w_timeout", 32'd0, 32'd1);
      @(posedge clk);
      model_write(w, wbuf_data[beat], wbuf_strb[beat]);
      w = w + 12'd1;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("b_timeout", 32'd0, 32'd1);
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), (last_beat == len) ? 32'd0 : 32'd2);
    @(negedge clk);
    bready = 1'b0;
    check("wready_after_b", 32'(wready), 32'd0);
    check("awready_after_b", 32'(awready), 32'd1);
  endtask

  // rmode: 0 = rready held high, 1 = toggling 1,0,1,0..., 2 = random
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                          input int rmode);
    int n;
    int lat;
    int beat;
    int k;
    logic rdy;
    logic [11:0] w;
    @(negedge clk);
    araddr = addr; arlen = 8'(len); arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check("ar_timeout", 32'd0, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 50) begin @(negedge clk); lat++; end
    check("rd_latency", 32'(lat), 32'(RD_LATENCY));
    w = addr[13:2]; beat = 0; k = 0;
    while (beat <= len && k < 3000) begin
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      rready = rdy;
      check("rvalid", 32'(rvalid), 32'd1);
      check("rdata", rdata, ref_mem[w]);
      check("rid", 32'(rid), 32'(id));
      check("rlast", 32'(rlast), 32'(beat == len));
      @(negedge clk);
      if (rdy) begin w = w + 12'd1; beat++; end
      k++;
    end
    rready = 1'b0;
    check("rvalid_end", 32'(rvalid), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    reset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arlock = '0;
    arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awlock = '0;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rid_bid", 32'({rid, bid}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_arready", 32'(arready), 32'd1);
    check("idle_awready", 32'(awready), 32'd1);

    // Fill the whole memory so every model word is known.
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 256; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
      axi_write(32'(blk * 1024), 255, 4'(blk), -1);
    end

    for (int i = 0; i < 4; i++) begin wbuf_data[i] = 32'hA0A0A0A0 + 32'h01010101 * i; wbuf_strb[i] = 4'hF; end
    axi_write(32'h100, 3, 4'd3, -1);
    axi_read(32'h100, 3, 4'd0, 0);

    wbuf_data[0] = 32'hFFFFFFFF; wbuf_strb[0] = 4'hF;
    axi_write(32'h20, 0, 4'd1, -1);
    wbuf_data[0] = 32'h11223344; wbuf_strb[0] = 4'b0101;
    axi_write(32'h20, 0, 4'd1, -1);
    axi_read(32'h20, 0, 4'd6, 0);

    for (int i = 0; i < 4; i++) begin wbuf_data[i] = 32'hB0B0B0B0 + 32'h01010101 * i; wbuf_strb[i] = 4'hF; end
    axi_write(32'h200, 3, 4'd4, -1);
    axi_read(32'h200, 3, 4'd7, 1);

    for (int i = 0; i < 4; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
    axi_write(32'h280, 3, 4'd9, 2);
    axi_read(32'h280, 3, 4'd9, 0);

    // Read and write beat to the same word in one cycle.
    wbuf_data[0] = 32'hAAAA0000; wbuf_strb[0] = 4'hF;
    axi_write(32'h300, 0, 4'd2, -1);
    @(negedge clk);
    awaddr = 32'h300; awlen = 8'd0; awid = 4'd2; awvalid = 1'b1;
    araddr = 32'h300; arlen = 8'd0; arid = 4'd8; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    check("rbw_rvalid", 32'(rvalid), 32'd1);
    check("rbw_wready", 32'(wready), 32'd1);
    check("rbw_old", rdata, 32'hAAAA0000);
    wvalid = 1'b1; wdata = 32'h00005555; wstrb = 4'hF; wlast = 1'b1; rready = 1'b1;
    @(posedge clk);
    model_write(12'h0C0, 32'h00005555, 4'hF);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    check("rbw_bresp", 32'(bresp), 32'd0);
    check("rbw_bid", 32'(bid), 32'd2);
    @(negedge clk);
    bready = 1'b0;
    axi_read(32'h300, 0, 4'd8, 0);

    // Reset while beat 1 of a 4-beat read is on the bus.
    @(negedge clk);
    araddr = 32'h100; arlen = 8'd3; arid = 4'd5; arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    check("rst_mid_beat1", rdata, ref_mem[12'h041]);
    reset = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_arready", 32'(arready), 32'd0);
    @(negedge clk);
    check("rst_mid_rvalid2", 32'(rvalid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_arready", 32'(arready), 32'd1);
    axi_read(32'h100, 3, 4'd5, 2);

    for (int it = 0; it < 12; it++) begin
      int len;
      a = {18'd0, 12'($urandom_range(0, DEPTH - 1)), 2'b00};
      len = $urandom_range(0, 7);
      for (int i = 0; i <= len; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'($urandom_range(0, 15)); end
      axi_write(a, len, 4'(it), -1);
      axi_read(a, len, 4'(15 - it), 2);
    end

    for (int i = 0; i < 6; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
    axi_write(32'h3FF8, 5, 4'd12, -1);
    axi_read(32'h3FF8, 5, 4'd13, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
